// File: rtl/axis_axi_burst_writer.sv
// -----------------------------------------------------------------------------
// axis_axi_burst_writer
//
// Write-side DMA stage. Takes a command (start byte address, beat count) and
// drains an AXI-Stream source into memory as AXI4 INCR write bursts. A
// transfer is split at MAX_BURST_LEN beats and at every 4 KB boundary. Only
// one burst is outstanding at a time. Completion is reported as a one-cycle
// pulse together with the beat count and the OR of all write-response errors.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_*                 command: byte address (low size bits ignored), beat
//                         count, valid/ready handshake
//   sts_*                 status: completion pulse, aggregated error, beats
//   s_axis_*              AXI-Stream data source (consumed only in DATA)
//   m_axi_aw*             AXI4 write-address channel
//   m_axi_w*              AXI4 write-data channel (pass-through of the stream)
//   m_axi_b*              AXI4 write-response channel
// -----------------------------------------------------------------------------
module axis_axi_burst_writer #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int AWID_VALUE    = 0,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,

  output logic                  sts_valid,
  output logic                  sts_error,
  output logic [LEN_WIDTH-1:0]  sts_beats,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,

  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,

  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,

  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int SIZE = $clog2(STRB_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    RESP,
    DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr_q;        // start address of the next burst
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]            awlen_q;
  logic                  awvalid_q;
  logic [8:0]            burst_beats_q; // beats of the burst in flight
  logic [7:0]            beat_cnt_q;    // beats left in burst, 0 = last
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  err_acc_q;
  logic                  cmd_ready_q;
  logic                  sts_error_q;
  logic [LEN_WIDTH-1:0]  sts_beats_q;

  logic cmd_fire, aw_fire, w_fire, b_fire, bresp_err;
  logic [31:0] rem_w, bnd_w, beats_w;
  logic [8:0]  burst_calc;

  // The write-response ID carries no information with a single fixed AWID.
  logic unused_bid;
  assign unused_bid = ^m_axi_bid;

  assign cmd_fire  = cmd_valid && cmd_ready_q;
  assign aw_fire   = awvalid_q && m_axi_awready;
  assign w_fire    = (state == DATA) && s_axis_tvalid && m_axi_wready;
  assign b_fire    = (state == RESP) && m_axi_bvalid;
  assign bresp_err = (m_axi_bresp != 2'b00);

  // Beats until the next 4 KB page: addr_q is size-aligned, so the division
  // by STRB_WIDTH is exact and the result is at least 1.
  assign rem_w = 32'(remaining_q);
  assign bnd_w = 32'(13'h1000 - {1'b0, addr_q[11:0]}) >> SIZE;

  // NOTE: every variable written in an always_comb gets a value on entry, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    beats_w = rem_w;
    if (beats_w > 32'(MAX_BURST_LEN)) beats_w = 32'(MAX_BURST_LEN);
    if (beats_w > bnd_w)              beats_w = bnd_w;
  end

  assign burst_calc = beats_w[8:0];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (cmd_fire) state_next = (cmd_len == '0) ? DONE : ADDR;
      ADDR: if (aw_fire) state_next = DATA;
      DATA: if (w_fire && beat_cnt_q == 8'd0) state_next = RESP;
      RESP: if (b_fire) state_next = (remaining_q == '0) ? DONE : ADDR;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q        <= '0;
      awaddr_q      <= '0;
      awlen_q       <= '0;
      awvalid_q     <= 1'b0;
      burst_beats_q <= '0;
      beat_cnt_q    <= '0;
      remaining_q   <= '0;
      len_q         <= '0;
      err_acc_q     <= 1'b0;
      cmd_ready_q   <= 1'b0;
      sts_error_q   <= 1'b0;
      sts_beats_q   <= '0;
    end else begin
      // Registered so it stays low through reset and rises one cycle after.
      cmd_ready_q <= (state_next == IDLE);

      unique case (state)
        IDLE: begin
          if (cmd_fire) begin
            addr_q      <= cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
            remaining_q <= cmd_len;
            len_q       <= cmd_len;
            err_acc_q   <= 1'b0;
            if (cmd_len == '0) begin
              sts_beats_q <= '0;
              sts_error_q <= 1'b0;
            end
          end
        end

        ADDR: begin
          // First ADDR cycle sizes the burst; awaddr/awlen then hold until
          // the slave takes them.
          if (!awvalid_q) begin
            awaddr_q      <= addr_q;
            awlen_q       <= 8'(burst_calc - 9'd1);
            burst_beats_q <= burst_calc;
            awvalid_q     <= 1'b1;
          end else if (m_axi_awready) begin
            awvalid_q  <= 1'b0;
            beat_cnt_q <= awlen_q;
          end
        end

        DATA: begin
          if (w_fire) begin
            if (beat_cnt_q == 8'd0) begin
              addr_q      <= addr_q + (ADDR_WIDTH'(burst_beats_q) << SIZE);
              remaining_q <= remaining_q - LEN_WIDTH'(burst_beats_q);
            end else begin
              beat_cnt_q <= beat_cnt_q - 8'd1;
            end
          end
        end

        RESP: begin
          if (b_fire) begin
            err_acc_q <= err_acc_q | bresp_err;
            if (remaining_q == '0) begin
              sts_beats_q <= len_q;
              sts_error_q <= err_acc_q | bresp_err;
            end
          end
        end

        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cmd_ready     = cmd_ready_q;
  assign sts_valid     = (state == DONE);
  assign sts_error     = sts_error_q;
  assign sts_beats     = sts_beats_q;

  assign m_axi_awid    = ID_WIDTH'(AWID_VALUE);
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;

  // Stream and W channel are joined combinationally, and only in DATA, so a
  // beat is consumed from the stream exactly when it is accepted by memory.
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = (state == DATA) && s_axis_tvalid;
  assign s_axis_tready = (state == DATA) && m_axi_wready;
  assign m_axi_wlast   = (state == DATA) && (beat_cnt_q == 8'd0);

  assign m_axi_bready  = (state == RESP);

endmodule

// File: tb/tb_axis_axi_burst_writer.sv
// -----------------------------------------------------------------------------
// tb_axis_axi_burst_writer
//
// Directed bench: a stream source and an AXI4 write slave with optional random
// ready/valid gaps, a word memory, and logs of AW, W, B and status traffic.
// Expected burst lists are written out by hand per command.
// -----------------------------------------------------------------------------
module tb_axis_axi_burst_writer;

  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int SW  = 4;
  localparam int IDW = 8;
  localparam int LW  = 16;

  logic           clk;
  logic           rst_n;
  logic [AW-1:0]  cmd_addr;
  logic [LW-1:0]  cmd_len;
  logic           cmd_valid;
  logic           cmd_ready;
  logic           sts_valid;
  logic           sts_error;
  logic [LW-1:0]  sts_beats;
  logic [DW-1:0]  s_axis_tdata;
  logic           s_axis_tvalid;
  logic           s_axis_tready;
  logic [IDW-1:0] m_axi_awid;
  logic [AW-1:0]  m_axi_awaddr;
  logic [7:0]     m_axi_awlen;
  logic [2:0]     m_axi_awsize;
  logic [1:0]     m_axi_awburst;
  logic           m_axi_awlock;
  logic [3:0]     m_axi_awcache;
  logic [2:0]     m_axi_awprot;
  logic           m_axi_awvalid;
  logic           m_axi_awready;
  logic [DW-1:0]  m_axi_wdata;
  logic [SW-1:0]  m_axi_wstrb;
  logic           m_axi_wlast;
  logic           m_axi_wvalid;
  logic           m_axi_wready;
  logic [IDW-1:0] m_axi_bid;
  logic [1:0]     m_axi_bresp;
  logic           m_axi_bvalid;
  logic           m_axi_bready;

  axis_axi_burst_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IDW),
    .AWID_VALUE(0), .MAX_BURST_LEN(16), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .sts_valid(sts_valid), .sts_error(sts_error), .sts_beats(sts_beats),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Source / slave / monitor state
  // ---------------------------------------------------------------------------
  logic [DW-1:0] src_q[$];
  int            src_idx;
  bit            src_hold;
  bit            gap_en;
  bit            wready_off;
  int            err_burst;
  int            b_pend;
  int            b_idx;

  logic [AW-1:0] aw_addr_log[$];
  logic [7:0]    aw_len_log[$];
  logic [DW-1:0] w_data_log[$];
  bit            w_last_log[$];
  int            stream_hs;
  logic [DW-1:0] mem[int];
  logic [AW-1:0] waddr;

  int            first_aw_cyc;
  int            b_cyc;
  int            sts_cnt;
  int            sts_cyc;
  int            acc_cyc;
  logic [LW-1:0] sts_beats_seen;
  logic          sts_err_seen;
  int            aw_unstable;
  bit            aw_wait;
  logic [AW-1:0] aw_prev_addr;
  logic [7:0]    aw_prev_len;

  logic [AW-1:0] exp_addr[$];
  logic [7:0]    exp_len[$];

  task automatic clear_logs();
    src_q.delete();
    src_idx = 0; src_hold = 0; b_pend = 0; b_idx = 0; err_burst = -1;
    aw_addr_log.delete(); aw_len_log.delete();
    w_data_log.delete();  w_last_log.delete();
    exp_addr.delete();    exp_len.delete();
    stream_hs = 0; mem.delete(); waddr = '0;
    first_aw_cyc = -1; b_cyc = -1; sts_cnt = 0; sts_cyc = -1; acc_cyc = -1;
    aw_unstable = 0; aw_wait = 0;
  endtask

  // Inputs are driven on the falling edge; handshakes are sampled 1 ns later,
  // which is exactly what the next rising edge will see.
  initial begin
    s_axis_tvalid = 0; s_axis_tdata = '0;
    m_axi_awready = 0; m_axi_wready = 0;
    m_axi_bvalid = 0;  m_axi_bresp = 2'b00; m_axi_bid = '0;
    forever begin
      @(negedge clk);
      s_axis_tvalid = (src_idx < src_q.size()) &&
                      (src_hold || !gap_en || ($urandom_range(0, 1) == 1));
      s_axis_tdata  = (src_idx < src_q.size()) ? src_q[src_idx] : '0;
      m_axi_wready  = !wready_off && (!gap_en || ($urandom_range(0, 1) == 1));
      m_axi_awready = !gap_en || ($urandom_range(0, 1) == 1);
      m_axi_bvalid  = (b_pend > 0);
      m_axi_bresp   = (b_pend > 0 && b_idx == err_burst) ? 2'b10 : 2'b00;
      #1;
      if (m_axi_awvalid) begin
        if (first_aw_cyc < 0) first_aw_cyc = cyc;
        if (aw_wait && (m_axi_awaddr !== aw_prev_addr || m_axi_awlen !== aw_prev_len))
          aw_unstable++;
        aw_prev_addr = m_axi_awaddr;
        aw_prev_len  = m_axi_awlen;
        if (m_axi_awready) begin
          aw_addr_log.push_back(m_axi_awaddr);
          aw_len_log.push_back(m_axi_awlen);
          waddr   = m_axi_awaddr;
          aw_wait = 0;
        end else begin
          aw_wait = 1;
        end
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_data_log.push_back(m_axi_wdata);
        w_last_log.push_back(m_axi_wlast);
        mem[int'(waddr >> 2)] = m_axi_wdata;
        waddr = waddr + 16'd4;
        if (m_axi_wlast) b_pend++;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        stream_hs++;
        src_idx++;
        src_hold = 0;
      end else begin
        src_hold = s_axis_tvalid;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_pend--;
        b_idx++;
        b_cyc = cyc;
      end
      if (sts_valid) begin
        sts_cnt++;
        sts_cyc        = cyc;
        sts_beats_seen = sts_beats;
        sts_err_seen   = sts_error;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command issue and result checking
  // ---------------------------------------------------------------------------
  task automatic issue_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
    int t;
    @(negedge clk);
    cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    #2;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clk); #2; t++;
    end
    acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic [AW-1:0] a,
                         input logic [LW-1:0] l, input logic [DW-1:0] seed);
    int t;
    for (int i = 0; i < int'(l); i++) src_q.push_back(seed + DW'(i));
    issue_cmd(a, l);
    #2;
    t = 0;
    while (sts_cnt == 0 && t < 3000) begin
      @(negedge clk); #2; t++;
    end
    repeat (3) @(negedge clk);
    #2;
    check({tag, "_sts_cnt"}, 64'(sts_cnt), 64'd1);
  endtask

  task automatic check_result(input string tag, input logic [AW-1:0] start,
                              input int len, input logic exp_err);
    int data_bad, last_bad, mem_bad, b, acc;
    bit exp_last;
    check({tag, "_aw_cnt"}, 64'(aw_addr_log.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < aw_addr_log.size(); i++) begin
      check($sformatf("%s_awaddr%0d", tag, i), 64'(aw_addr_log[i]), 64'(exp_addr[i]));
      check($sformatf("%s_awlen%0d", tag, i),  64'(aw_len_log[i]),  64'(exp_len[i]));
    end
    check({tag, "_w_cnt"},      64'(w_data_log.size()), 64'(len));
    check({tag, "_stream_cnt"}, 64'(stream_hs),         64'(len));
    data_bad = 0; last_bad = 0; mem_bad = 0;
    b = 0;
    acc = (exp_len.size() > 0) ? int'(exp_len[0]) + 1 : 0;
    for (int i = 0; i < w_data_log.size(); i++) begin
      exp_last = (i == acc - 1);
      if (i < src_q.size() && w_data_log[i] !== src_q[i]) data_bad++;
      if (w_last_log[i] != exp_last) last_bad++;
      if (exp_last && b + 1 < exp_len.size()) begin
        b++;
        acc += int'(exp_len[b]) + 1;
      end
    end
    for (int i = 0; i < len; i++) begin
      int k;
      k = int'(start >> 2) + i;
      if (!mem.exists(k) || mem[k] !== src_q[i]) mem_bad++;
    end
    check({tag, "_data_order"}, 64'(data_bad), 64'd0);
    check({tag, "_wlast_pos"},  64'(last_bad), 64'd0);
    check({tag, "_mem"},        64'(mem_bad),  64'd0);
    check({tag, "_sts_beats"},  64'(sts_beats_seen), 64'(len));
    check({tag, "_sts_error"},  64'(sts_err_seen),   64'(exp_err));
    check({tag, "_aw_stable"},  64'(aw_unstable),    64'd0);
    if (len > 0) begin
      check({tag, "_aw_latency"},  64'(first_aw_cyc - acc_cyc), 64'd2);
      check({tag, "_sts_latency"}, 64'(sts_cyc - b_cyc),        64'd1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int t;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    gap_en = 0; wready_off = 0;
    clear_logs();
    repeat (3) @(negedge clk);
    #2;
    check("rst_cmd_ready", 64'(cmd_ready),     64'd0);
    check("rst_awvalid",   64'(m_axi_awvalid), 64'd0);
    check("rst_bready",    64'(m_axi_bready),  64'd0);
    check("rst_sts_valid", 64'(sts_valid),     64'd0);
    check("rst_sts_beats", 64'(sts_beats),     64'd0);
    check("rst_sts_error", 64'(sts_error),     64'd0);
    check("awsize",  64'(m_axi_awsize),  64'd2);
    check("awburst", 64'(m_axi_awburst), 64'd1);
    check("awcache", 64'(m_axi_awcache), 64'd3);
    check("wstrb",   64'(m_axi_wstrb),   64'hf);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_cmd_ready", 64'(cmd_ready), 64'd1);

    // Single short burst.
    clear_logs();
    exp_addr.push_back(16'h0100); exp_len.push_back(8'd3);
    run_cmd("single", 16'h0100, 16'd4, 32'hA100_0000);
    check_result("single", 16'h0100, 4, 1'b0);

    // Split at MAX_BURST_LEN.
    clear_logs();
    exp_addr.push_back(16'h0000); exp_len.push_back(8'd15);
    exp_addr.push_back(16'h0040); exp_len.push_back(8'd15);
    exp_addr.push_back(16'h0080); exp_len.push_back(8'd7);
    run_cmd("split40", 16'h0000, 16'd40, 32'hA200_0000);
    check_result("split40", 16'h0000, 40, 1'b0);

    // Split at the 4 KB boundary.
    clear_logs();
    exp_addr.push_back(16'h0FF0); exp_len.push_back(8'd3);
    exp_addr.push_back(16'h1000); exp_len.push_back(8'd3);
    run_cmd("page4k", 16'h0FF0, 16'd8, 32'hA300_0000);
    check_result("page4k", 16'h0FF0, 8, 1'b0);

    // Unaligned start address is rounded down.
    clear_logs();
    exp_addr.push_back(16'h0200); exp_len.push_back(8'd0);
    run_cmd("unaligned", 16'h0203, 16'd1, 32'hA400_0000);
    check_result("unaligned", 16'h0200, 1, 1'b0);

    // Random source and slave gaps.
    clear_logs();
    gap_en = 1;
    exp_addr.push_back(16'h0300); exp_len.push_back(8'd15);
    exp_addr.push_back(16'h0340); exp_len.push_back(8'd3);
    run_cmd("gaps", 16'h0300, 16'd20, 32'hA500_0000);
    check_result("gaps", 16'h0300, 20, 1'b0);
    gap_en = 0;

    // Error response on the second of three bursts.
    clear_logs();
    err_burst = 1;
    exp_addr.push_back(16'h0400); exp_len.push_back(8'd15);
    exp_addr.push_back(16'h0440); exp_len.push_back(8'd15);
    exp_addr.push_back(16'h0480); exp_len.push_back(8'd7);
    run_cmd("berr", 16'h0400, 16'd40, 32'hA600_0000);
    check_result("berr", 16'h0400, 40, 1'b1);
    check("berr_b_count", 64'(b_idx), 64'd3);

    // Clean command afterwards clears the error.
    clear_logs();
    exp_addr.push_back(16'h0500); exp_len.push_back(8'd3);
    run_cmd("clean", 16'h0500, 16'd4, 32'hA700_0000);
    check_result("clean", 16'h0500, 4, 1'b0);

    // Zero-length command.
    clear_logs();
    run_cmd("zero", 16'h0600, 16'd0, 32'h0);
    check_result("zero", 16'h0600, 0, 1'b0);
    check("zero_no_aw",      64'(first_aw_cyc),          64'hffff_ffff_ffff_ffff);
    check("zero_sts_latency", 64'(sts_cyc - acc_cyc),    64'd1);

    // Reset while stalled in DATA.
    clear_logs();
    wready_off = 1;
    for (int i = 0; i < 8; i++) src_q.push_back(32'hA800_0000 + 32'(i));
    issue_cmd(16'h0700, 16'd8);
    #2;
    t = 0;
    while (!m_axi_wvalid && t < 50) begin
      @(negedge clk); #2; t++;
    end
    check("midrst_reached_data", 64'(m_axi_wvalid), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_wvalid",    64'(m_axi_wvalid),  64'd0);
    check("midrst_awvalid",   64'(m_axi_awvalid), 64'd0);
    check("midrst_bready",    64'(m_axi_bready),  64'd0);
    check("midrst_tready",    64'(s_axis_tready), 64'd0);
    check("midrst_cmd_ready", 64'(cmd_ready),     64'd0);
    @(negedge clk);
    clear_logs();
    wready_off = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_release_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (4) @(negedge clk);
    #2;
    check("midrst_no_sts", 64'(sts_cnt), 64'd0);
    check("midrst_no_aw",  64'(aw_addr_log.size()), 64'd0);

    // Recovery after reset.
    clear_logs();
    exp_addr.push_back(16'h0800); exp_len.push_back(8'd3);
    run_cmd("recover", 16'h0800, 16'd4, 32'hA900_0000);
    check_result("recover", 16'h0800, 4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_axi_burst_writer.md
Name: axis_axi_burst_writer

Overview:
- Write-side DMA stage directly upstream of the AXI4 RAM slave in the CDMA subsystem.
- Accepts a command (start byte address, beat count) and drains an AXI-Stream source into memory as INCR write bursts.
- Splits transfers at MAX_BURST_LEN beats and at 4 KB boundaries; one burst outstanding at a time.
- Reports completion and aggregated write-response error on a status port.

Parameters:
DATA_WIDTH, 32, AXI/AXIS data width in bits
ADDR_WIDTH, 16, AXI byte-address width; must be >= 12
STRB_WIDTH, DATA_WIDTH/8, write strobe width
ID_WIDTH, 8, AXI ID width
AWID_VALUE, 0, constant ID driven on m_axi_awid
MAX_BURST_LEN, 16, maximum beats per burst; range 1..256
LEN_WIDTH, 16, width of beat-count fields

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cmd_addr  in  ADDR_WIDTH  start byte address; low $clog2(STRB_WIDTH) bits ignored (treated as 0)
cmd_len  in  LEN_WIDTH  number of beats to write
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&&ready
sts_valid  out  1  one-cycle completion pulse
sts_error  out  1  1 if any burst returned bresp != OKAY
sts_beats  out  LEN_WIDTH  beats written (equals cmd_len)
s_axis_tdata  in  DATA_WIDTH  stream data
s_axis_tvalid  in  1  stream valid
s_axis_tready  out  1  stream ready
m_axi_awid  out  ID_WIDTH  = AWID_VALUE
m_axi_awaddr  out  ADDR_WIDTH  burst start address
m_axi_awlen  out  8  beats-1
m_axi_awsize  out  3  $clog2(STRB_WIDTH)
m_axi_awburst  out  2  2'b01 (INCR)
m_axi_awlock  out  1  0
m_axi_awcache  out  4  4'b0011
m_axi_awprot  out  3  3'b000
m_axi_awvalid  out  1  address valid
m_axi_awready  in  1  address ready
m_axi_wdata  out  DATA_WIDTH  = s_axis_tdata
m_axi_wstrb  out  STRB_WIDTH  all ones
m_axi_wlast  out  1  last beat of burst
m_axi_wvalid  out  1  data valid
m_axi_wready  in  1  data ready
m_axi_bid  in  ID_WIDTH  ignored
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  response valid
m_axi_bready  out  1  response ready

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; cmd_ready, sts_valid, sts_error, m_axi_awvalid, m_axi_bready = 0; sts_beats = 0; burst counters cleared. cmd_ready rises the first cycle after reset deasserts.
- States: IDLE, ADDR, DATA, RESP, DONE.
- IDLE: cmd_ready=1. On accept: latch address (aligned), remaining=cmd_len, clear error accumulator, cmd_ready->0. cmd_len==0 -> DONE with no AXI traffic. Otherwise -> ADDR.
- ADDR: burst beats = min(remaining, MAX_BURST_LEN, (4096 - addr[11:0]) / STRB_WIDTH). awvalid asserted the cycle after entry, with awaddr/awlen stable until awready. On awready: load beat counter -> DATA.
- DATA: m_axi_wvalid = s_axis_tvalid; s_axis_tready = m_axi_wready (combinational pass-through, DATA only; both 0 in other states). wlast=1 when beat counter==0. On the last handshake: addr += beats*STRB_WIDTH (wraps modulo 2^ADDR_WIDTH), remaining -= beats -> RESP.
- RESP: bready=1. On bvalid: error |= (bresp != 2'b00). If remaining==0 -> DONE, else -> ADDR.
- DONE: sts_valid=1 for exactly one cycle, sts_beats=cmd_len, sts_error=accumulator -> IDLE (cmd_ready=1 the next cycle).
- sts_error and sts_beats hold their values until the next DONE.
- The stream is never consumed outside DATA; no beats are dropped or duplicated under any tvalid/wready pattern.
- awaddr/awlen change only in ADDR when awvalid is low or awready is high.
- Latency: cmd accept to first awvalid = 2 cycles. Last bvalid to sts_valid = 1 cycle.
- Reset mid-operation: all valids drop at that edge, the command is discarded, no status pulse.

Test Plan:
- DATA_WIDTH=32, cmd_addr=0x0100, cmd_len=4, all-ready slave -> one AW (awaddr 0x0100, awlen 3), 4 W beats with wlast on the 4th, sts_valid with sts_beats=4, sts_error=0; memory words 0x40..0x43 match the stream.
- cmd_addr=0x0000, cmd_len=40 -> bursts at 0x0000/awlen 15, 0x0040/awlen 15, 0x0080/awlen 7; exactly 40 W beats.
- cmd_addr=0x0FF0, cmd_len=8 -> awaddr 0x0FF0/awlen 3 then 0x1000/awlen 3; no burst crosses 0x1000.
- Random tvalid and wready gaps (50%), cmd_len=20 -> data order preserved, 20 handshakes, wlast only on beats 16 and 20.
- Slave returns bresp=2'b10 on the 2nd of 3 bursts -> all 3 bursts still issued; sts_error=1. A following clean command -> sts_error=0.
- cmd_len=0 -> no awvalid; sts_valid 1 cycle after accept. rst_n low mid-DATA -> wvalid/awvalid/bready 0 next cycle, no sts_valid, cmd_ready=1 after release.
